// File: rtl/cam_frame_writer.sv
// rtl/cam_frame_writer.sv - packs RGB565 pixels into 256-bit beats and writes frames to DDR3 as fixed AXI bursts
// A frame restart requested mid-burst is held until the burst drains, then the FIFO and partial word are flushed.
module cam_frame_writer #(
    parameter logic [27:0] BASE_ADDR   = 28'h0000000,
    parameter int          FRAME_BEATS = 57600,
    parameter int          BURST_LEN   = 8,
    parameter int          FIFO_DEPTH  = 32,
    parameter logic [3:0]  AXI_ID      = 4'd0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          pix_valid,
    input  logic [15:0]   pix_data,
    output logic [27:0]   axi_awaddr,
    output logic          axi_awuser_ap,
    output logic [3:0]    axi_awuser_id,
    output logic [3:0]    axi_awlen,
    output logic          axi_awvalid,
    input  logic          axi_awready,
    output logic [255:0]  axi_wdata,
    output logic [31:0]   axi_wstrb,
    input  logic          axi_wready,
    input  logic [3:0]    axi_wusero_id,
    input  logic          axi_wusero_last,
    output logic          frame_done,
    output logic          overflow,
    output logic          busy
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int FBW = $clog2(FRAME_BEATS + 1);
    localparam int BLW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {WAIT_FRAME = 2'd0, IDLE = 2'd1, ADDR = 2'd2, DATA = 2'd3} state_t;

    state_t          r_state;
    logic [255:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_fifo_cnt;
    logic [255:0]    r_shift;
    logic [3:0]      r_lane;
    logic [FBW-1:0]  r_packed;
    logic [FBW-1:0]  r_written;
    logic [BLW-1:0]  r_beat;
    logic            r_restart_pend;

    logic            w_pop;
    logic            w_last_pop;
    logic            w_restart;
    logic            w_pix_ok;
    logic            w_word_done;
    logic            w_full;
    logic            w_push;
    logic [255:0]    w_word;
    logic            w_unused;

    assign w_unused      = ^{axi_wusero_id, axi_wusero_last};
    assign axi_awuser_ap = 1'b0;
    assign axi_awuser_id = AXI_ID;
    assign axi_awlen     = 4'(BURST_LEN - 1);
    assign axi_wstrb     = '1;
    assign axi_wdata     = (r_fifo_cnt != '0) ? r_mem[r_rd_ptr] : '0;
    assign busy          = (r_state != WAIT_FRAME) || (r_fifo_cnt != '0);

    assign w_pop       = (r_state == DATA) && axi_wready;
    assign w_last_pop  = w_pop && (r_beat == BLW'(BURST_LEN - 1));
    // In WAIT_FRAME/IDLE a restart is immediate; otherwise it waits for the burst's last pop.
    assign w_restart   = (r_state == WAIT_FRAME || r_state == IDLE) ? frame_start
                                                                      : ((r_restart_pend || frame_start) && w_last_pop);
    assign w_pix_ok    = pix_valid && !frame_start && !r_restart_pend && (r_state != WAIT_FRAME)
                         && (r_packed != FBW'(FRAME_BEATS));
    assign w_word_done = w_pix_ok && (r_lane == 4'd15);
    assign w_full      = (r_fifo_cnt == CW'(FIFO_DEPTH)) && !w_pop;
    assign w_push      = w_word_done && !w_full;
    // New pixels enter at the top lane so the first pixel of a word ends up in lane 0.
    assign w_word      = {pix_data, r_shift[255:16]};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= WAIT_FRAME;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_fifo_cnt     <= '0;
            r_shift        <= '0;
            r_lane         <= '0;
            r_packed       <= '0;
            r_written      <= '0;
            r_beat         <= '0;
            r_restart_pend <= 1'b0;
            axi_awaddr     <= BASE_ADDR;
            axi_awvalid    <= 1'b0;
            frame_done     <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_pix_ok) begin
                r_shift <= w_word;
                r_lane  <= r_lane + 4'd1;
                if (r_lane == 4'd15) begin
                    r_packed <= r_packed + FBW'(1);
                end
            end
            if (w_word_done && w_full) begin
                overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_written <= r_written + FBW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase

            case (r_state)
                WAIT_FRAME: begin
                end
                IDLE: begin
                    if (r_fifo_cnt >= CW'(BURST_LEN)) begin
                        r_state     <= ADDR;
                        axi_awvalid <= 1'b1;
                    end else if (r_written == FBW'(FRAME_BEATS)) begin
                        frame_done <= 1'b1;
                        r_state    <= WAIT_FRAME;
                    end
                end
                ADDR: begin
                    if (frame_start) begin
                        r_restart_pend <= 1'b1;
                    end
                    if (axi_awready) begin
                        axi_awvalid <= 1'b0;
                        r_beat      <= '0;
                        r_state     <= DATA;
                    end
                end
                DATA: begin
                    if (frame_start) begin
                        r_restart_pend <= 1'b1;
                    end
                    if (w_pop) begin
                        r_beat <= r_beat + BLW'(1);
                    end
                    if (w_last_pop) begin
                        r_beat     <= '0;
                        axi_awaddr <= axi_awaddr + 28'(BURST_LEN * 8);
                        r_state    <= IDLE;
                    end
                end
            endcase

            if (w_restart) begin
                r_state        <= IDLE;
                r_lane         <= '0;
                r_packed       <= '0;
                r_written      <= '0;
                r_wr_ptr       <= '0;
                r_rd_ptr       <= '0;
                r_fifo_cnt     <= '0;
                r_restart_pend <= 1'b0;
                overflow       <= 1'b0;
                frame_done     <= 1'b0;
                axi_awvalid    <= 1'b0;
                axi_awaddr     <= BASE_ADDR;
            end
        end
    end
endmodule
